// File: rtl/sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub_pkg
// Description : Shared types and constants for the signed subtract pipeline.
//               Provides the default operand/result widths, the default
//               output buffer depth, operand/result types, the operand
//               extreme constants and the buffer occupancy state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sub_pkg;

    localparam int SUB_WIDTH = 4;
    localparam int SUB_DEPTH = 2;

    typedef logic signed [SUB_WIDTH-1:0] operand_t;
    typedef logic signed [SUB_WIDTH:0]   result_t;

    localparam operand_t MAXPOS = operand_t'(7);
    localparam operand_t ZERO   = operand_t'(0);
    localparam operand_t MAXNEG = operand_t'(-8);

    // Occupancy of the output buffer.
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_t;

endpackage : sub_pkg
`default_nettype wire

// File: rtl/sub_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sub_fifo
// Description : Synchronous FIFO used as the result buffer of signed_sub_pipe.
//               Circular buffer of DEPTH entries (any depth, pointers wrap
//               explicitly), with an occupancy state machine tracking
//               EMPTY / PARTIAL / FULL.
// Ports       : clk    - clock, rising edge
//               rst    - synchronous active-high reset (clears contents too)
//               push   - write wdata (ignored when full)
//               pop    - advance head (ignored when empty)
//               wdata  - data to write
//               rdata  - head entry
//               count  - number of stored entries
//               full   - count == DEPTH
//               empty  - count == 0
// Revision    : 1.0 - initial release
// ============================================================================
module sub_fifo
    import sub_pkg::*;
#(
    parameter int DATA_W = SUB_WIDTH + 1,
    parameter int DEPTH  = SUB_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_DEPTH    = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    occ_t              r_occ;

    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_next;
    logic [PTR_W-1:0]  w_wr_ptr_next;
    logic [PTR_W-1:0]  w_rd_ptr_next;
    occ_t              w_occ_next;

    // Guard against overflow/underflow regardless of the caller's gating.
    // A pop never frees a slot for a same-cycle push: full is registered.
    assign w_push = push && (r_occ != OCC_FULL);
    assign w_pop  = pop  && (r_occ != OCC_EMPTY);

    assign w_wr_ptr_next = (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_next = (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Occupancy state machine: next state follows the next count.
    always_comb begin
        w_occ_next = r_occ;
        if (w_count_next == '0) begin
            w_occ_next = OCC_EMPTY;
        end else if (w_count_next == c_DEPTH) begin
            w_occ_next = OCC_FULL;
        end else begin
            w_occ_next = OCC_PARTIAL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ <= OCC_EMPTY;
        end else begin
            r_occ <= w_occ_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wdata;
                r_wr_ptr        <= w_wr_ptr_next;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_next;
            end
            r_count <= w_count_next;
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_occ == OCC_FULL);
    assign empty = (r_occ == OCC_EMPTY);

endmodule : sub_fifo
`default_nettype wire

// File: rtl/signed_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module      : signed_sub_pipe
// Description : Signed subtractor C = A - B at full WIDTH+1 precision with a
//               FIFO output buffer and valid/ready handshakes on both sides.
//               Results appear one cycle after the push when the buffer is
//               empty. Counts consumed results modulo 256.
// Ports       : clk       - clock, rising edge
//               reset     - synchronous active-high reset
//               A, B      - signed operands (minuend, subtrahend)
//               in_valid  - A/B valid this cycle
//               in_ready  - block accepts A/B this cycle
//               C         - head-of-buffer result (0 when empty)
//               out_valid - C holds a valid result
//               out_ready - consumer takes C this cycle
//               txn_count - results consumed, modulo 256
// Revision    : 1.0 - initial release
// ============================================================================
module signed_sub_pipe
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH,
    parameter int DEPTH = SUB_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH:0]   C,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       txn_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             w_in_ready;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic [7:0]       r_txn_count;

    // Both operands are sign-extended by one bit, so the difference always
    // fits and never wraps.
    assign w_diff = {A[WIDTH-1], A} - {B[WIDTH-1], B};

    // in_ready depends only on registered occupancy and reset; out_ready has
    // no path to it, so a pop cannot open a slot for a same-cycle push.
    assign w_in_ready = !w_full && !reset;
    assign w_push     = in_valid && w_in_ready;
    assign w_pop      = out_valid && out_ready && !reset;

    sub_fifo #(
        .DATA_W (WIDTH + 1),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_diff),
        .rdata (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_txn_count <= '0;
        end else if (w_pop) begin
            r_txn_count <= r_txn_count + 8'd1;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (w_count != '0);
    // Popped slots keep old data, so the head is masked when empty.
    assign C         = w_empty ? '0 : w_head;
    assign txn_count = r_txn_count;

endmodule : signed_sub_pipe
`default_nettype wire
